// File: rtl/k2_program_loader.sv
// K2 program loader: a valid/ready byte stream fills a 16x8 instruction RAM that is then
// served to K2_processor like a ROM. Optional macro K2_LOADER_CHECKSUM_EN adds a sum check.
module k2_program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              cpu_rst_n,
    input  logic [ADDR_W-1:0] ProgramAddress,
    output logic [DATA_W-1:0] instruction_data,
    output logic              loaded,
    output logic [ADDR_W:0]   prog_len
`ifdef K2_LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0] expected_sum,
    output logic [DATA_W-1:0] checksum,
    output logic              sum_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RELEASE,
        RUN
`ifdef K2_LOADER_CHECKSUM_EN
        ,
        ERROR
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_prog_len;
    logic                r_cpu_rst_n;
    logic                w_accept;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];
`ifdef K2_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   r_checksum;
`endif

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        wr_ready    = 1'b0;
        if (load_start) begin
            w_next = CLEAR;
        end else begin
            case (r_state)
                IDLE: w_next = IDLE;
                CLEAR: begin
                    w_mem_we = 1'b1;
                    if (r_ptr == LAST_ADDR) w_next = LOAD;
                end
                LOAD: begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        w_accept    = 1'b1;
                        w_mem_we    = 1'b1;
                        w_mem_wdata = wr_data;
                        if (wr_last || r_ptr == LAST_ADDR) w_next = RELEASE;
                    end
                end
                RELEASE: begin
`ifdef K2_LOADER_CHECKSUM_EN
                    w_next = (r_checksum == expected_sum) ? RUN : ERROR;
`else
                    w_next = RUN;
`endif
                end
                RUN: w_next = RUN;
`ifdef K2_LOADER_CHECKSUM_EN
                ERROR: w_next = ERROR;
`endif
                default: w_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_prog_len  <= '0;
            r_cpu_rst_n <= 1'b0;
`ifdef K2_LOADER_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            r_state     <= w_next;
            r_cpu_rst_n <= (w_next == RUN);
            if (load_start) begin
                r_ptr      <= '0;
                r_prog_len <= '0;
`ifdef K2_LOADER_CHECKSUM_EN
                r_checksum <= '0;
`endif
            end else if (r_state == CLEAR) begin
                r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + ADDR_W'(1);
            end else if (w_accept) begin
                // The pointer parks on the final entry instead of wrapping.
                if (w_next == LOAD) r_ptr <= r_ptr + ADDR_W'(1);
                if (r_prog_len != FULL_LEN) r_prog_len <= r_prog_len + (ADDR_W + 1)'(1);
`ifdef K2_LOADER_CHECKSUM_EN
                r_checksum <= r_checksum + wr_data;
`endif
            end
        end
    end

    // NOTE: the RAM has no reset; CLEAR is what zeroes it before each load.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) r_mem[r_ptr] <= w_mem_wdata;
    end

    assign instruction_data = (r_state == RUN) ? r_mem[ProgramAddress] : '0;
    assign cpu_rst_n        = r_cpu_rst_n;
    assign loaded           = (r_state == RUN);
    assign prog_len         = r_prog_len;
`ifdef K2_LOADER_CHECKSUM_EN
    assign checksum         = r_checksum;
    assign sum_err          = (r_state == ERROR);
`endif

endmodule

// File: doc/k2_program_loader.md
Name: k2_program_loader

Overview:
- Writer side of the K2 instruction-fetch interface: accepts a program byte stream over a valid/ready handshake and stores it in a 16x8 instruction RAM.
- Serves that RAM to K2_processor through the same ProgramAddress/instruction_data pair that a fixed program ROM drives.
- Holds the processor in reset while loading and releases it once the program is complete.
- Replaces hard-wired program ROMs in the exec tops, so any program can be run without re-synthesis.

Parameters:
- ADDR_W, 4, program address width; must equal the processor ProgramAddress width.
- DATA_W, 8, instruction width.
- DEPTH, 2**ADDR_W, number of instruction words (16).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse that begins a new load.
- wr_valid  in  1  byte on wr_data/wr_last is valid.
- wr_ready  out  1  loader accepts a byte this cycle.
- wr_data  in  DATA_W  instruction byte.
- wr_last  in  1  marks the final byte of the program.
- cpu_rst_n  out  1  drives K2_processor rst_n; registered.
- ProgramAddress  in  ADDR_W  fetch address from the processor.
- instruction_data  out  DATA_W  fetched instruction (combinational read).
- loaded  out  1  a program is resident and running.
- prog_len  out  ADDR_W+1  number of bytes accepted in the last load (0..16).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - Outputs: cpu_rst_n=0, wr_ready=0, loaded=0, prog_len=0, write pointer=0.
  - RAM contents are not reset.
- States and transitions:
  - IDLE: waits for load_start, then goes to CLEAR.
  - CLEAR: writes 0x00 to one RAM entry per cycle, addresses 0..DEPTH-1, taking 16 cycles. After the last entry, goes to LOAD with pointer=0.
  - LOAD: wr_ready=1. A byte is accepted when wr_valid && wr_ready.
    - Each accepted byte is written to RAM[pointer]; pointer and prog_len increment.
    - The load ends when the accepted byte has wr_last=1, or when it is the 16th byte. The 16th byte ends the load regardless of wr_last; further bytes get no ready.
    - The state goes to RELEASE on the cycle after the final accept.
  - RELEASE: one cycle, cpu_rst_n still 0, wr_ready=0. Then goes to RUN.
  - RUN: cpu_rst_n=1 and loaded=1. Stays in RUN until load_start or rst.
- load_start in any state other than IDLE:
  - Restarts the load: state goes to CLEAR and prog_len=0.
  - cpu_rst_n=0 and loaded=0 from the next cycle.
  - A byte presented in the same cycle is not accepted (wr_ready deasserts that cycle).
  - load_start has priority over all other events except rst.
- wr_valid outside LOAD is ignored; no RAM write occurs.
- instruction_data:
  - In RUN: instruction_data = RAM[ProgramAddress] combinationally, the same timing as a ROM.
  - In every other state it is forced to 0x00.
  - Addresses beyond prog_len read the 0x00 written during CLEAR.
- Latency: the final accept is at cycle N. RELEASE is at N+1; RUN and cpu_rst_n=1 take effect from N+2.
- Width rules: pointer is ADDR_W bits and never wraps, because the load ends at 16. prog_len saturates at DEPTH.

Optional Feature:
- Macro: K2_LOADER_CHECKSUM_EN.
- When defined:
  - Adds input expected_sum[DATA_W-1:0] and outputs checksum[DATA_W-1:0] and sum_err.
  - checksum is the mod-256 sum of all accepted bytes; it clears on load_start or rst.
  - In RELEASE, if checksum != expected_sum, the loader goes to ERROR instead of RUN.
  - ERROR: cpu_rst_n=0, loaded=0, sum_err=1. Exits only on load_start (to CLEAR, sum_err=0) or rst.
- When undefined: none of these ports or the ERROR state exist, and RELEASE always goes to RUN.

Test Plan:
- Five-byte load:
  - Stimulus: rst, then load_start, 16 CLEAR cycles, then bytes 0x1A,0x2B,0x3C,0x4D,0x5E with wr_last on 0x5E, wr_valid held high.
  - Response: prog_len=5; cpu_rst_n rises exactly 2 cycles after the 0x5E accept.
  - In RUN: ProgramAddress=2 reads 0x3C and ProgramAddress=9 reads 0x00.
- Full load: 20 bytes 0x01..0x14 with no wr_last -> only 0x01..0x10 accepted; wr_ready=0 from the 17th offer onward; prog_len=16; address 15 reads 0x10.
- Backpressure and bubbles: wr_valid toggled 1,0,0,1,1 with bytes 0xA0,0xA1,0xA2 (last) -> exactly 3 writes at addresses 0..2, prog_len=3.
- Restart mid-load: load_start asserted after 2 of 4 bytes, with a byte offered that same cycle -> that byte is not written; CLEAR reruns; RAM is all 0x00 before the new load; prog_len returns to 0.
- Reset in RUN: rst=1 for one cycle -> cpu_rst_n=0, loaded=0, instruction_data=0x00 at every address until a new load completes.
- Checksum (K2_LOADER_CHECKSUM_EN defined):
  - Load bytes 0x10,0x20 (last) with expected_sum=0x30 -> RUN.
  - Repeat with expected_sum=0x31 -> ERROR, sum_err=1, cpu_rst_n remains 0.
